dnn_mem_arbiter: RTL and testbench

DNN_MEM_ARBITER -- requirements
Module: dnn_mem_arbiter

---
 rtl/dnn_arb_pkg.sv | 30 +++
 rtl/dnn_arb_tag_fifo.sv | 46 ++++
 rtl/dnn_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dnn_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_arb_pkg.sv
// dnn_arb_pkg: shared types for the DNN memory arbiter, including the AMI
// request/response structs and the arbiter FSM state encoding.
package dnn_arb_pkg;

    localparam int NUM_REQ_MAX = 8;
    localparam int REQ_ID_W    = $clog2(NUM_REQ_MAX);
    localparam int AMI_ADDR_W  = 64;
    localparam int AMI_DATA_W  = 512;
    localparam int AMI_SIZE_W  = 64;

    typedef enum logic {
        IDLE,
        ISSUE
    } arb_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  isWrite;
        logic [AMI_ADDR_W-1:0] addr;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } AMIRequest;

    typedef struct packed {
        logic                  valid;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } AMIResponse;

endpackage

// File: rtl/dnn_arb_tag_fifo.sv
// dnn_arb_tag_fifo: in-order FIFO of requester ids for outstanding reads;
// the head id tells the arbiter which requester owns the next response.
module dnn_arb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + AW'(1);
            if (i_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_push_data;
    end

    assign o_head  = r_mem[r_rp];
    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/dnn_mem_arbiter.sv
// dnn_mem_arbiter: round-robin arbiter sharing one AMI memory port among
// NUM_REQ requesters, with in-order read response routing by tag FIFO.
// Optional grant statistics enabled by defining DNN_ARB_STATS_EN.
module dnn_mem_arbiter
    import dnn_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  AMIRequest                  req_in [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_grant,
    output AMIResponse                 resp_out [NUM_REQ],
    input  logic [NUM_REQ-1:0]         resp_grant,
    output AMIRequest                  mem_req,
    input  logic                       mem_req_grant,
    input  AMIResponse                 mem_resp,
    output logic                       mem_resp_grant,
    output logic                       err_orphan
`ifdef DNN_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [31:0]                stat_count
`endif
);

    localparam int CW = $clog2(TAG_DEPTH) + 1;

    arb_state_e            r_state;
    AMIRequest             r_mem_req;
    logic [REQ_ID_W-1:0]   r_rr_ptr;
    logic [REQ_ID_W-1:0]   r_req_id;
    logic                  r_err;
    logic [REQ_ID_W-1:0]   w_win;
    logic [REQ_ID_W-1:0]   w_head;
    logic                  w_found;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_head_rg;
    logic [NUM_REQ-1:0]    w_elig;
    logic [2*NUM_REQ-1:0]  w_dbl;
    logic [CW-1:0]         w_count;
    logic [CW:0]           w_occ;
    AMIRequest             w_sel;

    // A captured read that memory has not yet taken still needs a tag slot.
    assign w_occ = {1'b0, w_count} + (CW+1)'(r_mem_req.valid && !r_mem_req.isWrite);

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_elig[i] = req_in[i].valid &&
                        (req_in[i].isWrite || (!w_full && w_occ < (CW+1)'(TAG_DEPTH)));
    end

    // Rotate so bit 0 is the requester just after rr_ptr, then take the first set bit.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_dbl   = {w_elig, w_elig} >> (r_rr_ptr + REQ_ID_W'(1));
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_dbl[k]) begin
                w_found = 1'b1;
                w_win   = REQ_ID_W'((int'(r_rr_ptr) + 1 + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_win == REQ_ID_W'(i)) w_sel = req_in[i];
    end

    assign w_capture = w_found && (r_state == IDLE || mem_req_grant);
    assign w_push    = (r_state == ISSUE) && mem_req_grant && !r_mem_req.isWrite;
    assign w_pop     = mem_resp.valid && !w_empty && w_head_rg;

    always_comb begin
        req_grant = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_grant[i] = rst_n && w_capture && (w_win == REQ_ID_W'(i));
    end

    always_comb begin
        w_head_rg = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_out[i]       = mem_resp;
            resp_out[i].valid = mem_resp.valid && !w_empty && (w_head == REQ_ID_W'(i));
            if (w_head == REQ_ID_W'(i)) w_head_rg = resp_grant[i];
        end
    end

    // With no outstanding read, responses are drained so memory never stalls.
    assign mem_resp_grant = w_empty ? mem_resp.valid : w_head_rg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= REQ_ID_W'(NUM_REQ - 1);
            r_req_id  <= '0;
            r_mem_req <= '0;
            r_err     <= 1'b0;
        end else begin
            if (mem_resp.valid && w_empty) r_err <= 1'b1;
            if (w_capture) begin
                r_state   <= ISSUE;
                r_mem_req <= w_sel;
                r_req_id  <= w_win;
                r_rr_ptr  <= w_win;
            end else if (r_state == ISSUE && mem_req_grant) begin
                r_state         <= IDLE;
                r_mem_req.valid <= 1'b0;
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign err_orphan = r_err;

    dnn_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (REQ_ID_W)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_req_id),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

`ifdef DNN_ARB_STATS_EN
    logic [31:0] r_gnt_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) r_gnt_cnt[i] <= '0;
            stat_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_grant[i]) r_gnt_cnt[i] <= r_gnt_cnt[i] + 32'd1;
            stat_count <= r_gnt_cnt[stat_sel];
        end
    end
`endif

endmodule

// File: tb/tb_dnn_mem_arbiter.sv
// tb_dnn_mem_arbiter: scoreboard bench; directed requester traffic with
// hand-ordered expected grants, memory requests and routed responses.
module tb_dnn_mem_arbiter;
    import dnn_arb_pkg::*;

    localparam int NR = 4;
    localparam int TD = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    AMIRequest         req_in [NR];
    logic [NR-1:0]     req_grant;
    AMIResponse        resp_out [NR];
    logic [NR-1:0]     resp_grant;
    AMIRequest         mem_req;
    logic              mem_req_grant;
    AMIResponse        mem_resp;
    logic              mem_resp_grant;
    logic              err_orphan;
`ifdef DNN_ARB_STATS_EN
    logic [1:0]        stat_sel;
    logic [31:0]       stat_count;
`endif

    dnn_mem_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_in         (req_in),
        .req_grant      (req_grant),
        .resp_out       (resp_out),
        .resp_grant     (resp_grant),
        .mem_req        (mem_req),
        .mem_req_grant  (mem_req_grant),
        .mem_resp       (mem_resp),
        .mem_resp_grant (mem_resp_grant),
        .err_orphan     (err_orphan)
`ifdef DNN_ARB_STATS_EN
        ,
        .stat_sel       (stat_sel),
        .stat_count     (stat_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    AMIRequest   q_req [NR][$];
    int          exp_gnt [$];
    AMIRequest   exp_mreq [$];
    int          exp_rid [$];
    logic [63:0] exp_rdata [$];
    int          n_gnt [NR];
    logic [NR-1:0] g_snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic AMIRequest mk(input logic wr, input logic [63:0] a);
        AMIRequest r;
        r = '0;
        r.valid = 1'b1;
        r.isWrite = wr;
        r.addr = a;
        r.data[63:0] = ~a;
        r.size = 64'd64;
        return r;
    endfunction

    function automatic logic [NR-1:0] resp_valids();
        logic [NR-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i] = resp_out[i].valid;
        return v;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input int id, input logic wr, input logic [63:0] a);
        q_req[id].push_back(mk(wr, a));
    endtask

    task automatic expect_req(input int id, input logic wr, input logic [63:0] a);
        exp_gnt.push_back(id);
        exp_mreq.push_back(mk(wr, a));
    endtask

    task automatic expect_resp(input int id, input logic [63:0] d);
        exp_rid.push_back(id);
        exp_rdata.push_back(d);
    endtask

    task automatic wait_mresp_done();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = mem_resp_grant;
            @(posedge clk);
            #2;
        end
        if (!done) chk("resp_timeout", 0, 1);
        mem_resp.valid = 1'b0;
    endtask

    task automatic send_resp(input logic [63:0] d);
        mem_resp.valid = 1'b1;
        mem_resp.data = AMI_DATA_W'(d);
        wait_mresp_done();
    endtask

    task automatic wait_idle();
        bit busy;
        busy = 1'b1;
        for (int k = 0; k < 200 && busy; k++) begin
            busy = exp_gnt.size() != 0 || exp_mreq.size() != 0;
            for (int i = 0; i < NR; i++) if (q_req[i].size() != 0) busy = 1'b1;
            if (busy) step();
        end
        if (busy) chk("idle_timeout", 0, 1);
        step();
    endtask

    // Requester model: hold the head request until its grant is seen.
    initial begin
        for (int i = 0; i < NR; i++) req_in[i] = '0;
        forever begin
            @(negedge clk);
            g_snap = req_grant;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (g_snap[i] && q_req[i].size() > 0) void'(q_req[i].pop_front());
                req_in[i] = (q_req[i].size() > 0) ? q_req[i][0] : '0;
            end
        end
    end

    int          m_id;
    AMIRequest   m_req;
    int          m_rid;
    logic [63:0] m_rdata;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NR; i++) n_gnt[i] += int'(req_grant[i]);
            if (req_grant != '0) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(req_grant), 0);
                else begin
                    m_id = exp_gnt.pop_front();
                    chk("gnt", 64'(req_grant), 64'(1) << m_id);
                end
            end
            if (mem_req.valid && mem_req_grant) begin
                if (exp_mreq.size() == 0) chk("mreq_unexpected", mem_req.addr, 0);
                else begin
                    m_req = exp_mreq.pop_front();
                    chk("mreq_addr", mem_req.addr, m_req.addr);
                    chk("mreq_wr", 64'(mem_req.isWrite), 64'(m_req.isWrite));
                    chk("mreq_data", mem_req.data[63:0], m_req.data[63:0]);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (resp_out[i].valid && resp_grant[i]) begin
                    if (exp_rid.size() == 0) chk("resp_unexpected", 64'(i), 64'hFF);
                    else begin
                        m_rid = exp_rid.pop_front();
                        m_rdata = exp_rdata.pop_front();
                        chk("resp_id", 64'(i), 64'(m_rid));
                        chk("resp_data", resp_out[i].data[63:0], m_rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int first_c;
    int last_c;
    int n_mr;
    int g0;

    initial begin
        for (int i = 0; i < NR; i++) n_gnt[i] = 0;
        mem_req_grant = 1'b0;
        mem_resp = '0;
        resp_grant = '1;
`ifdef DNN_ARB_STATS_EN
        stat_sel = '0;
`endif
        step(3);
        chk("rst_mreq_valid", 64'(mem_req.valid), 0);
        chk("rst_req_grant", 64'(req_grant), 0);
        chk("rst_err_orphan", 64'(err_orphan), 0);
        chk("rst_resp_valid", 64'(resp_valids()), 0);
        rst_n = 1'b1;
        step(2);

        // Continuous reads from all requesters, one memory request per cycle
        mem_req_grant = 1'b1;
        issue(0, 0, 64'h1000); issue(0, 0, 64'h1010);
        issue(1, 0, 64'h1004); issue(2, 0, 64'h1008); issue(3, 0, 64'h100C);
        expect_req(0, 0, 64'h1000); expect_req(1, 0, 64'h1004);
        expect_req(2, 0, 64'h1008); expect_req(3, 0, 64'h100C);
        expect_req(0, 0, 64'h1010);
        first_c = -1; last_c = -1; n_mr = 0;
        for (int c = 0; c < 12; c++) begin
            if (mem_req.valid && mem_req_grant) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                n_mr++;
            end
            step();
        end
        chk("t1_mreq_count", 64'(n_mr), 5);
        chk("t1_mreq_span", 64'(last_c - first_c), 4);
        expect_resp(0, 64'h10); expect_resp(1, 64'h11); expect_resp(2, 64'h12);
        expect_resp(3, 64'h13); expect_resp(0, 64'h14);
        for (int k = 0; k < 5; k++) send_resp(64'h10 + 64'(k));
`ifdef DNN_ARB_STATS_EN
        stat_sel = 2'd0;
        step(2);
        chk("stat_r0", 64'(stat_count), 2);
`endif

        // Write held on mem_req while memory stalls
        mem_req_grant = 1'b0;
        g0 = n_gnt[2];
        issue(2, 1, 64'h40);
        expect_req(2, 1, 64'h40);
        for (int k = 0; k < 10 && !mem_req.valid; k++) step();
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", 64'(mem_req.valid), 1);
            chk("t2_hold_addr", mem_req.addr, 64'h40);
            step();
        end
        chk("t2_grant_pulses", 64'(n_gnt[2] - g0), 1);
        mem_req_grant = 1'b1;
        step(2);
        chk("t2_released", 64'(mem_req.valid), 0);

        // Tag FIFO full: reads stall, writes still pass
        for (int k = 0; k < TD; k++) begin
            issue(0, 0, 64'h2000 + 64'(k * 4));
            expect_req(0, 0, 64'h2000 + 64'(k * 4));
        end
        wait_idle();
        issue(3, 0, 64'h3000);
        issue(1, 1, 64'h3100);
        expect_req(1, 1, 64'h3100);
        step(8);
        chk("t3_read_blocked", 64'(q_req[3].size()), 1);
        chk("t3_write_passed", 64'(q_req[1].size()), 0);
        expect_req(3, 0, 64'h3000);
        expect_resp(0, 64'h55);
        send_resp(64'h55);
        wait_idle();
        chk("t3_read_granted", 64'(q_req[3].size()), 0);
        for (int k = 0; k < TD - 1; k++) expect_resp(0, 64'h60 + 64'(k));
        expect_resp(3, 64'h99);
        for (int k = 0; k < TD - 1; k++) send_resp(64'h60 + 64'(k));
        send_resp(64'h99);

        // Responses routed by issue order; stalled owner back-pressures memory
        issue(3, 0, 64'h4000); expect_req(3, 0, 64'h4000); wait_idle();
        issue(0, 0, 64'h4010); expect_req(0, 0, 64'h4010); wait_idle();
        issue(3, 0, 64'h4020); expect_req(3, 0, 64'h4020); wait_idle();
        resp_grant = 4'b1110;
        expect_resp(3, 64'hA);
        send_resp(64'hA);
        expect_resp(0, 64'hB);
        mem_resp.valid = 1'b1;
        mem_resp.data = AMI_DATA_W'(64'hB);
        for (int c = 0; c < 3; c++) begin
            chk("t4_backpressure", 64'(mem_resp_grant), 0);
            chk("t4_r0_valid", 64'(resp_valids()), 64'b0001);
            step();
        end
        resp_grant = '1;
        wait_mresp_done();
        expect_resp(3, 64'hC);
        send_resp(64'hC);

        // Orphan response is drained and flagged
        chk("t5_err_before", 64'(err_orphan), 0);
        mem_resp.valid = 1'b1;
        mem_resp.data = AMI_DATA_W'(64'hEE);
        chk("t5_drain_grant", 64'(mem_resp_grant), 1);
        chk("t5_no_resp_valid", 64'(resp_valids()), 0);
        step();
        mem_resp.valid = 1'b0;
        chk("t5_err_set", 64'(err_orphan), 1);
        step(3);
        chk("t5_err_sticky", 64'(err_orphan), 1);

        // Reset mid-ISSUE with outstanding tags
        issue(1, 0, 64'h5000); issue(2, 0, 64'h5004); issue(3, 0, 64'h5008);
        expect_req(1, 0, 64'h5000); expect_req(2, 0, 64'h5004); expect_req(3, 0, 64'h5008);
        wait_idle();
        mem_req_grant = 1'b0;
        issue(0, 1, 64'h6000);
        exp_gnt.push_back(0);
        for (int k = 0; k < 10 && !mem_req.valid; k++) step();
        step(2);
        chk("t6_issue_held", 64'(mem_req.valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mreq_valid", 64'(mem_req.valid), 0);
        chk("t6_rst_req_grant", 64'(req_grant), 0);
        chk("t6_rst_err", 64'(err_orphan), 0);
        step(2);
        rst_n = 1'b1;
        mem_req_grant = 1'b1;
        step();
`ifdef DNN_ARB_STATS_EN
        chk("t6_stat_zero", 64'(stat_count), 0);
`endif
        issue(1, 0, 64'h7004); issue(0, 0, 64'h7000);
        expect_req(0, 0, 64'h7000); expect_req(1, 0, 64'h7004);
        wait_idle();
        expect_resp(0, 64'hD); expect_resp(1, 64'hE);
        send_resp(64'hD);
        send_resp(64'hE);
        step(2);
        chk("t6_no_orphan", 64'(err_orphan), 0);

        chk("end_exp_gnt", 64'(exp_gnt.size()), 0);
        chk("end_exp_mreq", 64'(exp_mreq.size()), 0);
        chk("end_exp_resp", 64'(exp_rid.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
